pipereg_de_skid: RTL and testbench

- Parametrised decode-to-execute pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Carries NUM_SRC source operand channels (data and register address), a destination address and an extended immediate from decode into execute.
- Backpressure from execute no longer needs a combinational stall path into decode.
- Synchronous flush inserts bubbles. Saturating bubble and stall counters support performance monitoring.

---
 rtl/pipereg_de_skid.sv | 184 ++++++++++++++++++
 tb/tb_pipereg_de_skid.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipereg_de_skid.sv
// Decode-to-execute pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Registered in_ready; synchronous flush; saturating bubble/stall counters.
module pipereg_de_skid #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SRC*DATA_W-1:0] in_rd,
  input  logic [NUM_SRC*ADDR_W-1:0] in_ra,
  input  logic [ADDR_W-1:0]         in_wa,
  input  logic [DATA_W-1:0]         in_imm,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_SRC*DATA_W-1:0] out_rd,
  output logic [NUM_SRC*ADDR_W-1:0] out_ra,
  output logic [ADDR_W-1:0]         out_wa,
  output logic [DATA_W-1:0]         out_imm,
  output logic [CNT_W-1:0]          bubble_cnt,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int unsigned RD_W = NUM_SRC * DATA_W;
  localparam int unsigned RA_W = NUM_SRC * ADDR_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                main_valid_q, main_valid_d;
  logic                skid_valid_q, skid_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [RD_W-1:0]     main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
  logic [RA_W-1:0]     main_ra_q, main_ra_d, skid_ra_q, skid_ra_d;
  logic [ADDR_W-1:0]   main_wa_q, main_wa_d, skid_wa_q, skid_wa_d;
  logic [DATA_W-1:0]   main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
  logic [CNT_W-1:0]    bubble_q, bubble_d;
  logic [CNT_W-1:0]    stall_q, stall_d;

  logic accept;
  logic pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = main_valid_q & out_ready;

  always_comb begin
    state_d      = state_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    in_ready_d   = in_ready_q;
    main_rd_d    = main_rd_q;
    main_ra_d    = main_ra_q;
    main_wa_d    = main_wa_q;
    main_imm_d   = main_imm_q;
    skid_rd_d    = skid_rd_q;
    skid_ra_d    = skid_ra_q;
    skid_wa_d    = skid_wa_q;
    skid_imm_d   = skid_imm_q;

    if (flush) begin
      // Flush wins over accept and pop; a coincident accept is silently dropped.
      state_d      = EMPTY;
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      in_ready_d   = 1'b1;
      main_rd_d    = '0;
      main_ra_d    = '0;
      main_wa_d    = '0;
      main_imm_d   = '0;
      skid_rd_d    = '0;
      skid_ra_d    = '0;
      skid_wa_d    = '0;
      skid_imm_d   = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            main_valid_d = 1'b1;
            main_rd_d    = in_rd;
            main_ra_d    = in_ra;
            main_wa_d    = in_wa;
            main_imm_d   = in_imm;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_rd_d  = in_rd;
            main_ra_d  = in_ra;
            main_wa_d  = in_wa;
            main_imm_d = in_imm;
          end else if (accept) begin
            state_d      = TWO;
            skid_valid_d = 1'b1;
            in_ready_d   = 1'b0;
            skid_rd_d    = in_rd;
            skid_ra_d    = in_ra;
            skid_wa_d    = in_wa;
            skid_imm_d   = in_imm;
          end else if (pop) begin
            state_d      = EMPTY;
            main_valid_d = 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            state_d      = ONE;
            skid_valid_d = 1'b0;
            in_ready_d   = 1'b1;
            main_rd_d    = skid_rd_q;
            main_ra_d    = skid_ra_q;
            main_wa_d    = skid_wa_q;
            main_imm_d   = skid_imm_q;
          end
        end
        default: begin
          state_d      = EMPTY;
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
          in_ready_d   = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    stall_d  = stall_q;
    if (!main_valid_q && (bubble_q != '1)) bubble_d = bubble_q + CNT_W'(1);
    if (main_valid_q && !out_ready && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= EMPTY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      main_rd_q    <= '0;
      main_ra_q    <= '0;
      main_wa_q    <= '0;
      main_imm_q   <= '0;
      skid_rd_q    <= '0;
      skid_ra_q    <= '0;
      skid_wa_q    <= '0;
      skid_imm_q   <= '0;
      bubble_q     <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      main_rd_q    <= main_rd_d;
      main_ra_q    <= main_ra_d;
      main_wa_q    <= main_wa_d;
      main_imm_q   <= main_imm_d;
      skid_rd_q    <= skid_rd_d;
      skid_ra_q    <= skid_ra_d;
      skid_wa_q    <= skid_wa_d;
      skid_imm_q   <= skid_imm_d;
      bubble_q     <= bubble_d;
      stall_q      <= stall_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid_q;
  assign out_rd     = main_rd_q;
  assign out_ra     = main_ra_q;
  assign out_wa     = main_wa_q;
  assign out_imm    = main_imm_q;
  assign bubble_cnt = bubble_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_pipereg_de_skid.sv
// Scoreboard bench for pipereg_de_skid: the driver queues expected entries, a negedge monitor checks pops.
module tb_pipereg_de_skid;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned CNT_W   = 4;

  typedef struct packed {
    logic [63:0] rd;
    logic [7:0]  ra;
    logic [3:0]  wa;
    logic [31:0] imm;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_rd;
  logic [7:0]  in_ra;
  logic [3:0]  in_wa;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_rd;
  logic [7:0]  out_ra;
  logic [3:0]  out_wa;
  logic [31:0] out_imm;
  logic [3:0]  bubble_cnt;
  logic [3:0]  stall_cnt;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  ent_t        exp_q[$];

  pipereg_de_skid #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_SRC(NUM_SRC),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_ra     (in_ra),
    .in_wa     (in_wa),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rd    (out_rd),
    .out_ra    (out_ra),
    .out_wa    (out_wa),
    .out_imm   (out_imm),
    .bubble_cnt(bubble_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t mk(input logic [31:0] imm, input logic [3:0] wa);
    ent_t e;
    e.imm = imm;
    e.wa  = wa;
    e.rd  = {imm + 32'd2, imm + 32'd1};
    e.ra  = {wa + 4'd2, wa + 4'd1};
    return e;
  endfunction

  task automatic offer(input logic [31:0] imm, input logic [3:0] wa, input bit expect_accept);
    ent_t e;
    e        = mk(imm, wa);
    in_valid = 1'b1;
    in_rd    = e.rd;
    in_ra    = e.ra;
    in_wa    = e.wa;
    in_imm   = e.imm;
    if (expect_accept) exp_q.push_back(e);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_rd    = '0;
    in_ra    = '0;
    in_wa    = '0;
    in_imm   = '0;
  endtask

  task automatic chk_zero_payload(input string tag);
    chk({tag, "_rd"},  out_rd, 64'h0);
    chk({tag, "_ra"},  {56'h0, out_ra}, 64'h0);
    chk({tag, "_wa"},  {60'h0, out_wa}, 64'h0);
    chk({tag, "_imm"}, {32'h0, out_imm}, 64'h0);
  endtask

  // Monitor: a handshake visible at the negedge completes on the following posedge.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_pop: got imm 0x%0h with no entry pending", out_imm);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("pop_rd",  out_rd, e.rd);
        chk("pop_ra",  {56'h0, out_ra}, {56'h0, e.ra});
        chk("pop_wa",  {60'h0, out_wa}, {60'h0, e.wa});
        chk("pop_imm", {32'h0, out_imm}, {32'h0, e.imm});
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle_in();

    // Reset state
    repeat (2) tick();
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_in_ready",  {63'h0, in_ready},  64'h1);
    chk("rst_bubble",    {60'h0, bubble_cnt}, 64'h0);
    chk("rst_stall",     {60'h0, stall_cnt},  64'h0);
    chk_zero_payload("rst");
    reset_n = 1'b1;

    // Idle 5 cycles
    repeat (5) tick();
    chk("idle_out_valid", {63'h0, out_valid}, 64'h0);
    chk("idle_in_ready",  {63'h0, in_ready},  64'h1);
    chk("idle_bubble",    {60'h0, bubble_cnt}, 64'd5);
    chk("idle_stall",     {60'h0, stall_cnt},  64'd0);
    chk_zero_payload("idle");

    // Streaming with out_ready=1
    out_ready = 1'b1;
    offer(32'h11, 4'd1, 1'b1);
    tick();
    chk("st1_valid", {63'h0, out_valid}, 64'h1);
    chk("st1_imm",   {32'h0, out_imm}, 64'h11);
    chk("st1_ready", {63'h0, in_ready}, 64'h1);
    offer(32'h22, 4'd2, 1'b1);
    tick();
    chk("st2_valid", {63'h0, out_valid}, 64'h1);
    chk("st2_imm",   {32'h0, out_imm}, 64'h22);
    chk("st2_ready", {63'h0, in_ready}, 64'h1);
    offer(32'h33, 4'd3, 1'b1);
    tick();
    chk("st3_valid", {63'h0, out_valid}, 64'h1);
    chk("st3_imm",   {32'h0, out_imm}, 64'h33);
    chk("st3_ready", {63'h0, in_ready}, 64'h1);
    idle_in();
    tick();
    chk("st_drain_valid", {63'h0, out_valid}, 64'h0);
    chk("st_hold_imm",    {32'h0, out_imm}, 64'h33);
    chk("st_bubble",      {60'h0, bubble_cnt}, 64'd6);
    chk("st_stall",       {60'h0, stall_cnt},  64'd0);

    // Backpressure into the skid entry
    out_ready = 1'b0;
    offer(32'hA0, 4'd3, 1'b1);
    tick();
    chk("bp_a_ready", {63'h0, in_ready}, 64'h1);
    chk("bp_a_wa",    {60'h0, out_wa}, 64'd3);
    offer(32'hB0, 4'd5, 1'b1);
    tick();
    idle_in();
    chk("bp_two_ready", {63'h0, in_ready}, 64'h0);
    chk("bp_two_wa",    {60'h0, out_wa}, 64'd3);
    chk("bp_two_valid", {63'h0, out_valid}, 64'h1);
    chk("bp_stall1",    {60'h0, stall_cnt}, 64'd1);
    tick();
    chk("bp_stall2",      {60'h0, stall_cnt}, 64'd2);
    chk("bp_hold_ready",  {63'h0, in_ready}, 64'h0);
    chk("bp_hold_wa",     {60'h0, out_wa}, 64'd3);
    out_ready = 1'b1;
    tick();
    chk("bp_pop1_ready", {63'h0, in_ready}, 64'h1);
    chk("bp_pop1_wa",    {60'h0, out_wa}, 64'd5);
    tick();
    chk("bp_pop2_valid", {63'h0, out_valid}, 64'h0);
    chk("bp_stall_end",  {60'h0, stall_cnt}, 64'd2);
    chk("bp_bubble_end", {60'h0, bubble_cnt}, 64'd7);

    // Flush in TWO with a coincident offer that must vanish
    out_ready = 1'b0;
    offer(32'hC0, 4'd1, 1'b1);
    tick();
    offer(32'hD0, 4'd2, 1'b1);
    tick();
    chk("fl_two_ready", {63'h0, in_ready}, 64'h0);
    offer(32'hDEAD, 4'd7, 1'b0);
    flush = 1'b1;
    tick();
    exp_q.delete();
    flush = 1'b0;
    idle_in();
    chk("fl_valid",  {63'h0, out_valid}, 64'h0);
    chk("fl_ready",  {63'h0, in_ready}, 64'h1);
    chk_zero_payload("fl");
    chk("fl_stall",  {60'h0, stall_cnt}, 64'd4);
    chk("fl_bubble", {60'h0, bubble_cnt}, 64'd8);
    out_ready = 1'b1;
    repeat (2) tick();
    chk("fl_after_valid",  {63'h0, out_valid}, 64'h0);
    chk("fl_after_imm",    {32'h0, out_imm}, 64'h0);
    chk("fl_after_bubble", {60'h0, bubble_cnt}, 64'd10);

    // Asynchronous reset mid-cycle while in ONE
    out_ready = 1'b0;
    offer(32'hE0, 4'd4, 1'b1);
    tick();
    idle_in();
    chk("ar_pre_valid", {63'h0, out_valid}, 64'h1);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("ar_valid",  {63'h0, out_valid}, 64'h0);
    chk("ar_ready",  {63'h0, in_ready}, 64'h1);
    chk("ar_imm",    {32'h0, out_imm}, 64'h0);
    chk("ar_bubble", {60'h0, bubble_cnt}, 64'd0);
    chk("ar_stall",  {60'h0, stall_cnt}, 64'd0);
    tick();
    reset_n = 1'b1;

    // Bubble counter saturation with CNT_W=4
    repeat (14) tick();
    chk("sat_14", {60'h0, bubble_cnt}, 64'd14);
    repeat (6) tick();
    chk("sat_15", {60'h0, bubble_cnt}, 64'd15);

    // First entry after reset release appears one cycle after accept
    out_ready = 1'b1;
    offer(32'hF0, 4'd6, 1'b1);
    tick();
    idle_in();
    chk("post_valid",  {63'h0, out_valid}, 64'h1);
    chk("post_imm",    {32'h0, out_imm}, 64'hF0);
    chk("post_bubble", {60'h0, bubble_cnt}, 64'd15);
    repeat (2) tick();
    chk("post_drain",  {63'h0, out_valid}, 64'h0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
